// File: rtl/hex_display_arbiter_if.sv
// rtl/hex_display_arbiter_if.sv - request, grant and segment bundle between the two display sources and the arbiter
// master drives the requests and segment data; slave is the arbiter side.
interface hex_display_arbiter_if;
  logic        tick;
  logic        hold;
  logic        name_req;
  logic [41:0] name_leds;
  logic        gen_req;
  logic [41:0] gen_leds;
  logic        name_gnt;
  logic        gen_gnt;
  logic [6:0]  leds5;
  logic [6:0]  leds4;
  logic [6:0]  leds3;
  logic [6:0]  leds2;
  logic [6:0]  leds1;
  logic [6:0]  leds0;

  modport master (
    output tick, hold, name_req, name_leds, gen_req, gen_leds,
    input  name_gnt, gen_gnt, leds5, leds4, leds3, leds2, leds1, leds0
  );

  modport slave (
    input  tick, hold, name_req, name_leds, gen_req, gen_leds,
    output name_gnt, gen_gnt, leds5, leds4, leds3, leds2, leds1, leds0
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - time-shares six HEX displays between a pattern-name and a generation-counter source
// Define HEX_SCROLL_EN to rotate the name digits one position per effective tick while name owns the displays.
module hex_display_arbiter #(
  parameter int DWELL = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hex_display_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_NAME, S_GEN, S_GAP} state_t;

  localparam logic [3:0]  LP_LAST  = 4'(DWELL - 1);
  localparam logic [41:0] LP_BLANK = '1;

  state_t      r_state;
  logic [3:0]  r_dwell;
  logic        r_prev_name;
  logic        r_name_gnt;
  logic        r_gen_gnt;
  logic [41:0] r_leds;

  state_t      w_next;
  logic        w_eff;
  logic        w_expire;
  logic [41:0] w_name_view;

  assign w_eff    = bus.tick & ~bus.hold;
  assign w_expire = w_eff && (r_dwell == LP_LAST);

`ifdef HEX_SCROLL_EN
  logic [2:0] r_ofs;

  // Rotating left by 7*k moves digit 5-k onto HEX5.
  always_comb begin
    w_name_view = bus.name_leds;
    case (r_ofs)
      3'd1:    w_name_view = {bus.name_leds[34:0], bus.name_leds[41:35]};
      3'd2:    w_name_view = {bus.name_leds[27:0], bus.name_leds[41:28]};
      3'd3:    w_name_view = {bus.name_leds[20:0], bus.name_leds[41:21]};
      3'd4:    w_name_view = {bus.name_leds[13:0], bus.name_leds[41:14]};
      3'd5:    w_name_view = {bus.name_leds[6:0],  bus.name_leds[41:7]};
      default: w_name_view = bus.name_leds;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ofs <= '0;
    end else if (r_state != S_NAME && w_next == S_NAME) begin
      r_ofs <= '0;
    end else if (r_state == S_NAME && w_eff) begin
      r_ofs <= (r_ofs == 3'd5) ? 3'd0 : r_ofs + 3'd1;
    end
  end
`else
  assign w_name_view = bus.name_leds;
`endif

  // A dropped owner request and a dwell expiry both land in GAP, so the drop needs no special case.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.name_req)     w_next = S_NAME;
        else if (bus.gen_req) w_next = S_GEN;
      end
      S_NAME: begin
        if (!bus.name_req || (w_expire && bus.gen_req)) w_next = S_GAP;
      end
      S_GEN: begin
        if (!bus.gen_req || (w_expire && bus.name_req)) w_next = S_GAP;
      end
      S_GAP: begin
        if (r_prev_name) begin
          if (bus.gen_req)       w_next = S_GEN;
          else if (bus.name_req) w_next = S_NAME;
          else                   w_next = S_IDLE;
        end else begin
          if (bus.name_req)      w_next = S_NAME;
          else if (bus.gen_req)  w_next = S_GEN;
          else                   w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_dwell     <= '0;
      r_prev_name <= 1'b0;
      r_name_gnt  <= 1'b0;
      r_gen_gnt   <= 1'b0;
      r_leds      <= LP_BLANK;
    end else begin
      r_state    <= w_next;
      r_name_gnt <= (w_next == S_NAME);
      r_gen_gnt  <= (w_next == S_GEN);

      if (r_state != S_GAP && w_next == S_GAP)
        r_prev_name <= (r_state == S_NAME);

      if (w_next != r_state)
        r_dwell <= '0;
      else if (w_eff && r_dwell != LP_LAST && (r_state == S_NAME || r_state == S_GEN))
        r_dwell <= r_dwell + 4'd1;

      case (r_state)
        S_NAME:  r_leds <= w_name_view;
        S_GEN:   r_leds <= bus.gen_leds;
        default: r_leds <= LP_BLANK;
      endcase
    end
  end

  assign bus.name_gnt = r_name_gnt;
  assign bus.gen_gnt  = r_gen_gnt;
  assign bus.leds5    = r_leds[41:35];
  assign bus.leds4    = r_leds[34:28];
  assign bus.leds3    = r_leds[27:21];
  assign bus.leds2    = r_leds[20:14];
  assign bus.leds1    = r_leds[13:7];
  assign bus.leds0    = r_leds[6:0];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb/tb_hex_display_arbiter.sv - directed and randomized checks of hex_display_arbiter against an owner/tick-count model
// Built with or without HEX_SCROLL_EN to match the design.
module tb_hex_display_arbiter;
  localparam int DWELL = 8;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  hex_display_arbiter_if bus ();

  hex_display_arbiter #(.DWELL(DWELL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the displays, how many effective ticks they have had, and whether a gap cycle is running.
  int          m_owner;
  int          m_last;
  int          m_ticks;
  int          m_k;
  bit          m_gap;
  logic [41:0] m_leds;

  function automatic logic [41:0] rotl7(input logic [41:0] x, input int k);
    logic [83:0] d;
    d = {x, x} << (7 * k);
    return d[83:42];
  endfunction

  function automatic logic [41:0] rand42();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[41:0];
  endfunction

  function automatic logic [41:0] out_leds();
    return {bus.leds5, bus.leds4, bus.leds3, bus.leds2, bus.leds1, bus.leds0};
  endfunction

  function automatic void model_reset();
    m_owner = 0; m_last = 0; m_ticks = 0; m_k = 0; m_gap = 0;
    m_leds  = '1;
  endfunction

  function automatic void model_grant(input int who);
    m_owner = who; m_ticks = 0; m_k = 0;
  endfunction

  function automatic bit req_of(input int who);
    return (who == 1) ? bus.name_req : bus.gen_req;
  endfunction

  function automatic void model_edge();
    bit eff;
    if (!reset_n) begin
      model_reset();
      return;
    end
    eff = bus.tick && !bus.hold;
    if (m_gap || m_owner == 0) m_leds = '1;
`ifdef HEX_SCROLL_EN
    else if (m_owner == 1)     m_leds = rotl7(bus.name_leds, m_k);
`else
    else if (m_owner == 1)     m_leds = bus.name_leds;
`endif
    else                       m_leds = bus.gen_leds;

    if (m_gap) begin
      m_gap = 0;
      if (req_of(3 - m_last))  model_grant(3 - m_last);
      else if (req_of(m_last)) model_grant(m_last);
      else                     m_owner = 0;
    end else if (m_owner == 0) begin
      if (bus.name_req)      model_grant(1);
      else if (bus.gen_req)  model_grant(2);
    end else if (!req_of(m_owner) || (eff && m_ticks >= DWELL - 1 && req_of(3 - m_owner))) begin
      m_last = m_owner; m_owner = 0; m_gap = 1;
    end else if (eff) begin
      m_ticks = m_ticks + 1;
      m_k = (m_k + 1) % 6;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.tick = 0; bus.hold = 0; bus.name_req = 0; bus.gen_req = 0;
    bus.name_leds = rand42(); bus.gen_leds = rand42();
    model_reset();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.tick = 0; bus.hold = 0; bus.name_req = 1; bus.gen_req = 1;
    bus.name_leds = rand42(); bus.gen_leds = rand42();
    model_reset();
    step(); step();
    checks++;
    if (out_leds() !== '1 || bus.name_gnt !== 1'b0 || bus.gen_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_state: leds=%h gnt=%b%b expected leds=3ffffffffff gnt=00", out_leds(), bus.name_gnt, bus.gen_gnt);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (bus.name_gnt !== 1'b1 || bus.gen_gnt !== 1'b0) begin
      errors++; $display("FAIL first_grant: gnt=%b%b expected 10", bus.name_gnt, bus.gen_gnt);
    end
    step();
    checks++;
    if (out_leds() !== bus.name_leds) begin
      errors++; $display("FAIL first_leds: leds=%h expected %h", out_leds(), bus.name_leds);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_leds() !== '1 || bus.name_gnt !== 1'b0) begin
      errors++; $display("FAIL async_reset: leds=%h name_gnt=%b expected all ones and 0", out_leds(), bus.name_gnt);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (bus.name_gnt !== 1'b1 || bus.gen_gnt !== 1'b0) begin
      errors++; $display("FAIL regrant_after_reset: gnt=%b%b expected 10", bus.name_gnt, bus.gen_gnt);
    end
  endtask

  task automatic test_handover();
    do_reset();
    bus.gen_req = 1;
    step();
    checks++;
    if (bus.gen_gnt !== 1'b1 || bus.name_gnt !== 1'b0) begin
      errors++; $display("FAIL gen_grant: gnt=%b%b expected 01", bus.name_gnt, bus.gen_gnt);
    end
    bus.name_req = 1;
    for (int i = 1; i <= DWELL; i++) begin
      bus.tick = 1; step(); bus.tick = 0;
      checks++;
      if (bus.gen_gnt !== (i < DWELL) || bus.name_gnt !== 1'b0) begin
        errors++; $display("FAIL dwell_tick%0d: gnt=%b%b expected 0%b", i, bus.name_gnt, bus.gen_gnt, i < DWELL);
      end
      step();
    end
    checks++;
    if (bus.name_gnt !== 1'b1 || bus.gen_gnt !== 1'b0 || out_leds() !== '1) begin
      errors++; $display("FAIL after_gap: gnt=%b%b leds=%h expected 10 and blank", bus.name_gnt, bus.gen_gnt, out_leds());
    end
    step();
    checks++;
    if (out_leds() !== bus.name_leds) begin
      errors++; $display("FAIL name_leds_after_handover: leds=%h expected %h", out_leds(), bus.name_leds);
    end
  endtask

  task automatic test_drop(input bit other);
    do_reset();
    bus.gen_req = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.tick = 1; step(); bus.tick = 0; step();
    end
    bus.gen_req = 0; bus.name_req = other;
    step();
    checks++;
    if (bus.gen_gnt !== 1'b0 || bus.name_gnt !== 1'b0) begin
      errors++; $display("FAIL drop_gap: gnt=%b%b expected 00", bus.name_gnt, bus.gen_gnt);
    end
    step();
    checks++;
    if (bus.name_gnt !== other || bus.gen_gnt !== 1'b0 || out_leds() !== '1) begin
      errors++; $display("FAIL drop_next: gnt=%b%b leds=%h expected %b0 and blank", bus.name_gnt, bus.gen_gnt, out_leds(), other);
    end
  endtask

  task automatic test_hold();
    do_reset();
    bus.name_req = 1; bus.gen_req = 1;
    step();
    bus.hold = 1;
    for (int i = 0; i < 20; i++) begin
      bus.tick = 1; step(); bus.tick = 0;
      checks++;
      if (bus.name_gnt !== 1'b1 || bus.gen_gnt !== 1'b0) begin
        errors++; $display("FAIL hold_tick%0d: gnt=%b%b expected 10", i, bus.name_gnt, bus.gen_gnt);
      end
      step();
    end
    bus.hold = 0;
    for (int i = 1; i <= DWELL; i++) begin
      bus.tick = 1; step(); bus.tick = 0;
      checks++;
      if (bus.name_gnt !== (i < DWELL) || bus.gen_gnt !== 1'b0) begin
        errors++; $display("FAIL release_tick%0d: gnt=%b%b expected %b0", i, bus.name_gnt, bus.gen_gnt, i < DWELL);
      end
      step();
    end
    checks++;
    if (bus.gen_gnt !== 1'b1 || bus.name_gnt !== 1'b0) begin
      errors++; $display("FAIL hold_handover: gnt=%b%b expected 01", bus.name_gnt, bus.gen_gnt);
    end
  endtask

  task automatic test_drop_expire();
    do_reset();
    bus.gen_req = 1;
    step();
    bus.name_req = 1;
    for (int i = 0; i < DWELL - 1; i++) begin
      bus.tick = 1; step(); bus.tick = 0; step();
    end
    bus.tick = 1; bus.gen_req = 0;
    step();
    bus.tick = 0;
    checks++;
    if (bus.gen_gnt !== 1'b0 || bus.name_gnt !== 1'b0) begin
      errors++; $display("FAIL drop_expire_gap: gnt=%b%b expected 00", bus.name_gnt, bus.gen_gnt);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.name_gnt !== 1'b1 || bus.gen_gnt !== 1'b0) begin
        errors++; $display("FAIL drop_expire_owner%0d: gnt=%b%b expected 10", i, bus.name_gnt, bus.gen_gnt);
      end
    end
  endtask

`ifdef HEX_SCROLL_EN
  task automatic test_scroll();
    logic [41:0] d;
    int idx;
    do_reset();
    d = rand42();
    bus.name_leds = d; bus.name_req = 1;
    step(); step();
    for (int j = 0; j < 7; j++) begin
      idx = 5 - (j % 6);
      checks++;
      if (bus.leds5 !== d[7*idx +: 7]) begin
        errors++; $display("FAIL scroll_step%0d: leds5=%h expected %h", j, bus.leds5, d[7*idx +: 7]);
      end
      bus.tick = 1; step(); bus.tick = 0; step();
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bus.name_req  = ($urandom_range(0, 9) < 7);
      bus.gen_req   = ($urandom_range(0, 9) < 7);
      bus.tick      = $urandom_range(0, 1);
      bus.hold      = ($urandom_range(0, 4) == 0);
      bus.name_leds = rand42();
      bus.gen_leds  = rand42();
      step();
      checks++;
      if (bus.name_gnt !== (!m_gap && m_owner == 1) || bus.gen_gnt !== (!m_gap && m_owner == 2) || out_leds() !== m_leds) begin
        errors++; $display("FAIL random_cycle%0d: gnt=%b%b leds=%h expected %b%b %h", i, bus.name_gnt, bus.gen_gnt, out_leds(), (!m_gap && m_owner == 1), (!m_gap && m_owner == 2), m_leds);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_handover();
    test_drop(1'b0);
    test_drop(1'b1);
    test_hold();
    test_drop_expire();
`ifdef HEX_SCROLL_EN
    test_scroll();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 Parameter: DWELL, default 8, number of ticks a requester keeps the displays while the other requester waits (legal 2..15).
REQ-002 clk  input  1  system clock; the only clock in the block.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  single-cycle advance pulse from the external clock divider.
REQ-005 hold  input  1  when high, tick is ignored.
REQ-006 name_req  input  1  pattern-name source requests the displays.
REQ-007 name_leds  input  42  pattern-name segments; bits [41:35] digit 5 down to [6:0] digit 0; active-low.
REQ-008 gen_req  input  1  generation-counter source requests the displays.
REQ-009 gen_leds  input  42  generation-counter segments; same packing as name_leds.
REQ-010 name_gnt, gen_gnt  output  1 each  grant flags; at most one high.
REQ-011 leds5..leds0  output  7 each  registered segment drive for HEX5..HEX0; active-low.

Function
REQ-012 States: IDLE, NAME, GEN, GAP; name_gnt is high only in NAME and gen_gnt only in GEN.
REQ-013 IDLE: if name_req is high, go to NAME next cycle; else if gen_req is high, go to GEN; else stay in IDLE (name wins when both requests are high).
REQ-014 Entering NAME or GEN clears the 4-bit dwell counter; each effective tick (tick high, hold low) increments it, saturating at DWELL-1.
REQ-015 In NAME/GEN, if the owner's request drops, go to GAP next cycle.
REQ-016 In NAME/GEN, if an effective tick arrives with the counter at DWELL-1 and the other request high, go to GAP; if the other request is low, keep ownership and stay saturated.
REQ-017 GAP lasts exactly one clock and drives all outputs blank; next state: the non-previous requester if requesting, else the previous requester if requesting, else IDLE.
REQ-018 On each rising edge, leds5..leds0 load from the granted source (1-cycle latency); in IDLE and GAP they load 7'b1111111.
REQ-019 An owner-request drop and a dwell expiry in the same cycle resolve as the drop (GAP, then the other requester).
REQ-020 hold does not block state transitions caused by request changes.

Reset
REQ-021 While reset_n is low: state is IDLE, dwell counter is 0, scroll offset is 0, both grants are low, and all leds outputs are 7'b1111111, independent of clk.
REQ-022 Reset asserted mid-grant takes effect immediately; the first grant after release follows the IDLE rules.

Configuration
REQ-023 Macro HEX_SCROLL_EN defined: in NAME, a 3-bit offset k advances on each effective tick, wrapping 5 to 0, and clears on entering NAME; leds take name_leds rotated left by 7*k bits (k=1: leds5 shows digit 4 and leds0 shows digit 5).
REQ-024 Macro HEX_SCROLL_EN undefined: the offset logic is absent and name_leds are shown statically; all other behaviour is identical.

Verification
REQ-025 Reset low with both requests high -> all leds 7'h7F and both grants 0; after release, name_gnt=1 on the next edge, and leds equal name_leds one clock later.
REQ-026 gen_req only, then name_req rises, DWELL=8 -> gen_gnt holds for 8 effective ticks, then 1 GAP cycle blank, then name_gnt=1.
REQ-027 Owner request drops at dwell count 3 -> GAP next cycle, then the other requester if high, else IDLE with blank outputs.
REQ-028 hold=1 with 20 ticks while both requests are high -> no grant change and dwell counter frozen; release hold -> handover after the remaining ticks.
REQ-029 HEX_SCROLL_EN, name_leds digits d5..d0, 7 ticks -> leds5 sequence d5,d4,d3,d2,d1,d0,d5 (wrap).
REQ-030 Owner drop and dwell expiry in the same cycle -> single GAP, then the other requester granted, with no double grant.
